// File: rtl/arb_pkg.sv
// Shared state encoding for the grant controller and its bench.
package arb_pkg;

  localparam logic [1:0] ARB_IDLE    = 2'd0;
  localparam logic [1:0] ARB_GRANT   = 2'd1;
  localparam logic [1:0] ARB_RECOVER = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE    = ARB_IDLE,
    S_GRANT   = ARB_GRANT,
    S_RECOVER = ARB_RECOVER
  } arb_state_t;

endpackage

// File: rtl/arb_hold_timer.sv
// Grant hold counter: cleared on grant acceptance, counts while granted,
// flags expiry when the count reaches tmo-1 (tmo==0 never expires).
module arb_hold_timer #(
  parameter int TMO_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr,
  input  logic             en,
  input  logic [TMO_W-1:0] tmo,
  output logic             expire
);

  logic [TMO_W-1:0] r_cnt;
  logic [TMO_W-1:0] w_last;

  // Free-running wrap keeps a lowered tmo from firing early: it matches on the next pass.
  always_ff @(posedge clk_i) begin
    if (rst_i)    r_cnt <= '0;
    else if (clr) r_cnt <= '0;
    else if (en)  r_cnt <= r_cnt + TMO_W'(1);
  end

  assign w_last = tmo - TMO_W'(1);
  assign expire = (tmo != '0) && (r_cnt == w_last);

endmodule

// File: rtl/arb_grant_ctrl.sv
// Grant controller sitting behind an arbiter tree: latches the winner,
// holds a one-hot grant until release, timeout or higher-priority preemption,
// then inserts one dead RECOVER cycle before returning to IDLE.
module arb_grant_ctrl
  import arb_pkg::*;
#(
  parameter int N         = 8,
  parameter int PRIO_BITS = 3,
  parameter int TMO_W     = 8,
  localparam int SEL_W    = $clog2(N)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 arb_req_i,
  input  logic [SEL_W-1:0]     arb_sel_i,
  input  logic [PRIO_BITS-1:0] arb_prio_i,
  input  logic [N-1:0]         done_i,
  input  logic [TMO_W-1:0]     tmo_i,
  input  logic                 preempt_en_i,
  output logic [N-1:0]         gnt_o,
  output logic                 gnt_valid_o,
  output logic [SEL_W-1:0]     gnt_sel_o,
  output logic [PRIO_BITS-1:0] gnt_prio_o,
  output logic                 tmo_o,
  output logic                 preempt_o
);

  arb_state_t           r_state;
  logic [N-1:0]         r_gnt;
  logic                 r_gnt_valid;
  logic [SEL_W-1:0]     r_sel;
  logic [PRIO_BITS-1:0] r_prio;
  logic                 r_tmo;
  logic                 r_preempt;

  logic w_clr, w_en, w_done, w_expire, w_preempt;

  assign w_clr     = (r_state == S_IDLE) && arb_req_i;
  assign w_en      = (r_state == S_GRANT);
  // Only the granted source's release strobe matters.
  assign w_done    = done_i[r_sel];
  assign w_preempt = preempt_en_i && arb_req_i && (arb_prio_i < r_prio);

  arb_hold_timer #(.TMO_W(TMO_W)) u_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr    (w_clr),
    .en     (w_en),
    .tmo    (tmo_i),
    .expire (w_expire)
  );

  // Grant FSM; every output is a register, exit causes ranked release > timeout > preempt.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
      r_sel       <= '0;
      r_prio      <= '0;
      r_tmo       <= 1'b0;
      r_preempt   <= 1'b0;
    end else begin
      r_tmo     <= 1'b0;
      r_preempt <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (arb_req_i) begin
            r_sel       <= arb_sel_i;
            r_prio      <= arb_prio_i;
            r_gnt       <= N'(1) << arb_sel_i;
            r_gnt_valid <= 1'b1;
            r_state     <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (w_done || w_expire || w_preempt) begin
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_tmo       <= !w_done && w_expire;
            r_preempt   <= !w_done && !w_expire && w_preempt;
            r_state     <= S_RECOVER;
          end
        end
        S_RECOVER: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_gnt       <= '0;
          r_gnt_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt_o       = r_gnt;
  assign gnt_valid_o = r_gnt_valid;
  assign gnt_sel_o   = r_sel;
  assign gnt_prio_o  = r_prio;
  assign tmo_o       = r_tmo;
  assign preempt_o   = r_preempt;

endmodule

// File: doc/arb_grant_ctrl.md
ARB_GRANT_CTRL -- requirements
Module: arb_grant_ctrl

Interface
REQ-001 SHALL have parameter N, default 8: number of sources; power of two, at least 2.
REQ-002 SHALL have parameter PRIO_BITS, default 3: priority width; value 0 is the highest priority.
REQ-003 SHALL have parameter TMO_W, default 8: hold-timer width.
REQ-004 SHALL have port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port arb_req_i, input, 1: arbiter tree output request (any source requesting).
REQ-007 SHALL have port arb_sel_i, input, $clog2(N): index of the winning source from the arbiter tree.
REQ-008 SHALL have port arb_prio_i, input, PRIO_BITS: priority of the winning source.
REQ-009 SHALL have port done_i, input, N: per-source release strobe.
REQ-010 SHALL have port tmo_i, input, TMO_W: maximum grant hold in cycles; 0 disables the timeout.
REQ-011 SHALL have port preempt_en_i, input, 1: enables preemption.
REQ-012 SHALL have port gnt_o, output, N: one-hot grant.
REQ-013 SHALL have port gnt_valid_o, output, 1: high when gnt_o is non-zero.
REQ-014 SHALL have port gnt_sel_o, output, $clog2(N): index of the granted source.
REQ-015 SHALL have port gnt_prio_o, output, PRIO_BITS: latched priority of the granted source.
REQ-016 SHALL have port tmo_o, output, 1: one-cycle pulse when a grant ends by timeout.
REQ-017 SHALL have port preempt_o, output, 1: one-cycle pulse when a grant ends by preemption.

Function
REQ-018 SHALL implement a three-state FSM: IDLE, GRANT, RECOVER.
REQ-019 IDLE: when arb_req_i=1, SHALL latch arb_sel_i and arb_prio_i, clear the hold counter, and move to GRANT; otherwise SHALL stay in IDLE.
REQ-020 SHALL drive all outputs from registers; gnt_o[sel] rises the cycle after the IDLE sample (1-cycle latency).
REQ-021 GRANT: SHALL hold gnt_o one-hot at the latched index, with gnt_sel_o and gnt_prio_o stable, and SHALL increment the hold counter each cycle.
REQ-022 GRANT exit on release: done_i[latched sel]=1 SHALL move the FSM to RECOVER; done_i bits of non-granted sources SHALL be ignored.
REQ-023 GRANT exit on timeout: with tmo_i!=0 and counter==tmo_i-1, SHALL move to RECOVER and pulse tmo_o in the first RECOVER cycle.
REQ-024 GRANT exit on preemption: with preempt_en_i=1, arb_req_i=1 and arb_prio_i strictly less than the latched priority, SHALL move to RECOVER and pulse preempt_o in the first RECOVER cycle.
REQ-025 Equal-priority requests SHALL never preempt.
REQ-026 Simultaneous exit causes SHALL resolve as release > timeout > preemption; only the winning cause's pulse fires.
REQ-027 RECOVER: SHALL hold gnt_o=0 for exactly one cycle, then move to IDLE.
REQ-028 The earliest regrant after a grant ends SHALL be 3 cycles after the exit cycle (RECOVER, IDLE sample, then grant).
REQ-029 tmo_i SHALL be sampled live each cycle during GRANT; if tmo_i changes to a value at or below the current count, the timeout SHALL fire at the next counter wrap, with no early exit.
REQ-030 In IDLE and RECOVER, gnt_sel_o and gnt_prio_o SHALL hold their last latched values; gnt_valid_o SHALL equal |gnt_o at all times.

Reset
REQ-031 While rst_i=1, the FSM SHALL go to IDLE and gnt_o, gnt_valid_o, gnt_sel_o, gnt_prio_o, tmo_o, preempt_o and the hold counter SHALL all be 0.
REQ-032 A reset asserted during GRANT SHALL drop gnt_o on the following edge, with no RECOVER cycle and no pulse.

Structure
REQ-033 State encoding localparams (IDLE=0, GRANT=1, RECOVER=2) SHALL live in the shared package arb_pkg, used by RTL and bench.
REQ-034 The hold counter and compare SHALL be one sub-module, arb_hold_timer, with ports clr, en, tmo and expire.

Verification
REQ-035 Bench SHALL check single request: arb_req_i=1, sel=5, prio=2 in IDLE -> next cycle gnt_o=8'b0010_0000, gnt_prio_o=2; done_i[5] -> gnt_o=0 for 1 cycle.
REQ-036 Bench SHALL check foreign done: granted sel=3, done_i=8'b0000_0001 -> grant held.
REQ-037 Bench SHALL check timeout: tmo_i=4, no done -> gnt_o high exactly 4 cycles, then tmo_o pulses once.
REQ-038 Bench SHALL check preemption: granted prio=5, preempt_en_i=1, arb request prio=1 sel=6 -> preempt_o pulse, 1 dead cycle, then grant to 6; repeating with prio=5 causes no preemption.
REQ-039 Bench SHALL check collision: done_i[sel] and timeout expiry in the same cycle -> tmo_o stays 0.
REQ-040 Bench SHALL check reset mid-grant: rst_i=1 during GRANT -> all outputs 0 next cycle, FSM in IDLE, and no pulses.
